instr_fetch_queue: RTL and testbench

//   Consumer end of the program-counter interface. Takes the PC address and stop flag,

---
 rtl/instr_fetch_queue.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Consumer end of the program-counter interface. Issues one read per PC value
//   to a synchronous instruction memory (1-cycle read latency), tags each returned
//   word with the PC that fetched it, and buffers {word, tag} in a small FIFO that
//   feeds the FP decode/execute stage. The PC is back-pressured through pc_hold,
//   so a fetched word is never dropped.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous reset, active low
//   pc_in        in   ADDR_W   current PC from the program counter
//   pc_stop      in   1        PC has passed its last address; no further fetches
//   pc_hold      out  1        1 = PC must not advance this cycle
//   imem_addr    out  ADDR_W   instruction memory read address (= pc_in)
//   imem_rd_en   out  1        read strobe; imem_rdata valid the following cycle
//   imem_rdata   in   INSTR_W  read data, 1 cycle after imem_rd_en
//   instr_out    out  INSTR_W  head-of-FIFO instruction
//   instr_pc     out  ADDR_W   PC tag of instr_out
//   instr_valid  out  1        FIFO non-empty
//   instr_ready  in   1        downstream accepts the head when valid
//   done         out  1        program fully fetched and drained (sticky)
//
// Handshake: a word moves downstream on any rising edge where instr_valid and
//   instr_ready are both 1. While instr_valid=1 and instr_ready=0, instr_out and
//   instr_pc hold stable and instr_valid stays 1. On the PC side, issue and PC
//   advance are the same event (pc_hold = ~imem_rd_en), so every address is read
//   exactly once.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               pc_stop,
   output logic               pc_hold,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_rd_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

   // FIFO storage (no reset needed: entries are only read while count != 0)
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [ADDR_W-1:0]  fifo_pc    [DEPTH];

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               inflight;
   logic [ADDR_W-1:0]  tag;
   logic               done_q;

   // Last word handed downstream; shown on the outputs while the FIFO is empty
   logic [INSTR_W-1:0] last_instr;
   logic [ADDR_W-1:0]  last_pc;

   logic [CNT_W:0]     occupancy;
   logic               credit;
   logic               issue;
   logic               push;
   logic               pop;
   logic               fifo_nonempty;

   // A read in flight already owns a FIFO slot, so counting it here guarantees
   // the returning word always has room, even when a pop and a push coincide.
   always_comb begin
      occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
      credit        = occupancy < DEPTH_OCC;
      // rst_n gates issue so the memory sees no strobe while reset is held
      issue         = rst_n & credit & ~pc_stop & ~done_q;
      push          = inflight;
      fifo_nonempty = (count != '0);
      pop           = fifo_nonempty & instr_ready;
   end

   assign imem_rd_en = issue;
   assign imem_addr  = pc_in;
   assign pc_hold    = ~issue;

   // In-flight tracking: one read outstanding at most per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         tag      <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag <= pc_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_instr <= '0;
         last_pc    <= '0;
      end else if (pop) begin
         last_instr <= fifo_instr[rd_ptr];
         last_pc    <= fifo_pc[rd_ptr];
      end
   end

   // Program is complete once the PC has stopped and nothing is buffered or
   // outstanding; pc_stop already blocks issue, so no new work can appear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else if (pc_stop && !inflight && (count == '0) && !push) begin
         done_q <= 1'b1;
      end
   end

   assign done        = done_q;
   assign instr_valid = fifo_nonempty;
   assign instr_out   = fifo_nonempty ? fifo_instr[rd_ptr] : last_instr;
   assign instr_pc    = fifo_nonempty ? fifo_pc[rd_ptr]    : last_pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst_n;
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_stop;
  logic               pc_hold;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               done;

  instr_fetch_queue #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_stop    (pc_stop),
    .pc_hold    (pc_hold),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .done       (done)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [INSTR_W+ADDR_W-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int pops = 0;
  logic [ADDR_W-1:0] last_tag = '0;
  int last_pop_cyc = 0;
  int first_valid_cyc = -1;
  int rel_cyc = 0;
  int ready_mode = 0;
  logic last_rd = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // ---------------- monitor: pops and compares ----------------
  initial begin
    bit pv;
    bit pr;
    logic [INSTR_W+ADDR_W-1:0] pout;
    logic [INSTR_W+ADDR_W-1:0] e;
    pv = 0;
    pr = 0;
    pout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        continue;
      end
      check(int'(dut.count) <= DEPTH, "count_bound", 64'(dut.count), 64'(DEPTH));
      if (dut.inflight) check(int'(dut.count) < DEPTH, "push_at_full", 64'(dut.count), 64'(DEPTH-1));
      if (pv && !pr)
        check(instr_valid && ({instr_out, instr_pc} == pout), "hold_stable",
              {instr_valid, instr_out, instr_pc}, {1'b1, pout});
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready) begin
        check(exp_q.size() != 0, "pop_expected", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({instr_out, instr_pc} == e, "pop_data", {instr_out, instr_pc}, e);
        end
        pops++;
        last_tag = instr_pc;
        last_pop_cyc = cyc;
      end
      pv = instr_valid;
      pr = instr_ready;
      pout = {instr_out, instr_pc};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready(input int m);
    ready_mode = m;
    instr_ready = (m == 2) ? 1'($urandom_range(0, 1)) : (m == 1);
  endtask

  // One clock: sample at negedge, model PC and memory, drive at posedge+1
  task automatic step();
    logic s_rd;
    logic s_hold;
    logic [ADDR_W-1:0] s_addr;
    @(negedge clk);
    s_rd = imem_rd_en;
    s_hold = pc_hold;
    s_addr = imem_addr;
    if (pc_stop) check(!s_rd, "rd_after_stop", 64'(s_rd), 64'd0);
    if (s_rd) begin
      check(s_addr == pc_in, "imem_addr", 64'(s_addr), 64'(pc_in));
      exp_q.push_back({mem_word(pc_in), pc_in});
    end
    last_rd = s_rd;
    last_addr = s_addr;
    @(posedge clk);
    #1;
    imem_rdata = s_rd ? mem_word(s_addr) : 32'hDEAD_BEEF;
    if (!s_hold) begin
      if (pc_in == 8'hFF) pc_stop = 1'b1;
      else pc_in = pc_in + 8'd1;
    end
    if (ready_mode == 2) instr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pc_in = '0;
    pc_stop = 1'b0;
    set_ready(0);
    #1;
    check(!instr_valid, "rst_valid", 64'(instr_valid), 64'd0);
    check(!done, "rst_done", 64'(done), 64'd0);
    check(pc_hold, "rst_pc_hold", 64'(pc_hold), 64'd1);
    check(!imem_rd_en, "rst_rd_en", 64'(imem_rd_en), 64'd0);
    check({instr_out, instr_pc} == '0, "rst_out", {instr_out, instr_pc}, 64'd0);
    exp_q.delete();
    pops = 0;
    first_valid_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_to_done(input bit check_rate);
    int budget;
    budget = 0;
    while (!done && budget < 3000) begin
      step();
      budget++;
    end
    check(done, "done_reached", 64'(done), 64'd1);
    check(pops == 256, "word_count", 64'(pops), 64'd256);
    check(last_tag == 8'hFF, "last_tag", 64'(last_tag), 64'hFF);
    check(exp_q.size() == 0, "exp_drained", 64'(exp_q.size()), 64'd0);
    check(cyc - last_pop_cyc <= 3, "done_lag", 64'(cyc - last_pop_cyc), 64'd3);
    check(first_valid_cyc - rel_cyc == 2, "fill_latency", 64'(first_valid_cyc - rel_cyc), 64'd2);
    if (check_rate)
      check(last_pop_cyc - first_valid_cyc == 255, "throughput",
            64'(last_pop_cyc - first_valid_cyc), 64'd255);
    // empty pops after completion
    set_ready(1);
    repeat (4) step();
    check(!instr_valid, "empty_valid", 64'(instr_valid), 64'd0);
    check(dut.count == 0, "empty_count", 64'(dut.count), 64'd0);
    check(done, "done_sticky", 64'(done), 64'd1);
    check({instr_out, instr_pc} == {32'hA000_00FF, 8'hFF}, "hold_last",
          {instr_out, instr_pc}, {32'hA000_00FF, 8'hFF});
  endtask

  // ---------------- global guard ----------------
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running, required done");
    chk_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    pc_in = '0;
    pc_stop = 1'b0;

    // 1: streaming with instr_ready held high
    do_reset();
    set_ready(1);
    run_to_done(1'b1);

    // 2: back-pressure from cycle 0
    do_reset();
    set_ready(0);
    repeat (8) step();
    check(pc_in == 8'd4, "bp_pc_frozen", 64'(pc_in), 64'd4);
    check(pc_hold, "bp_pc_hold", 64'(pc_hold), 64'd1);
    check(dut.count == 4, "bp_count", 64'(dut.count), 64'd4);
    check(instr_valid && {instr_out, instr_pc} == {32'hA000_0000, 8'h00}, "bp_head",
          {instr_valid, instr_out, instr_pc}, {1'b1, 32'hA000_0000, 8'h00});

    // 3: single pop while full -> exactly one refill with tag 4
    set_ready(1);
    step();
    set_ready(0);
    repeat (3) step();
    check(pc_in == 8'd5, "full_pc", 64'(pc_in), 64'd5);
    check(dut.count == 4, "full_count", 64'(dut.count), 64'd4);
    check(pc_hold, "full_pc_hold", 64'(pc_hold), 64'd1);
    check({instr_out, instr_pc} == {32'hA000_0001, 8'h01}, "full_head",
          {instr_out, instr_pc}, {32'hA000_0001, 8'h01});
    set_ready(1);
    run_to_done(1'b0);

    // 4: random downstream readiness to end of program
    do_reset();
    set_ready(2);
    run_to_done(1'b0);

    // 5: reset while a read for PC 0x10 is in flight, then restart
    do_reset();
    set_ready(1);
    begin
      int budget;
      budget = 0;
      while (!(last_rd && last_addr == 8'h10) && budget < 100) begin
        step();
        budget++;
      end
    end
    check(dut.inflight == 1'b1, "mid_inflight", 64'(dut.inflight), 64'd1);
    do_reset();
    set_ready(1);
    run_to_done(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
